frv_pipeline_ctrl: RTL and testbench

FRV_PIPELINE_CTRL -- requirements
Module: frv_pipeline_ctrl

---
 rtl/frv_pipeline_ctrl.sv | 170 +++++++++++++++++
 tb/tb_frv_pipeline_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frv_pipeline_ctrl.sv
// frv_pipeline_ctrl
//   Pipeline hazard / redirect controller for an NSTAGE-deep in-order pipe.
//   Stage 0 is the youngest. It computes per-stage ready (backpressure),
//   per-stage flush, the fetch redirect handshake, and WFI sleep.
//
//   Optional feature macro: FRV_PIPELINE_CTRL_PERF_EN enables the stall and
//   flush performance counters. Without it the ports are tied to 0.
//
// Ports
//   g_clk, g_resetn         clock, async active-low reset
//   s_valid[NSTAGE]         valid at the output of each stage register
//   s_stall[NSTAGE]         stage cannot consume its input this cycle
//   s_ready[NSTAGE]         ready into each stage register (combinational)
//   s_flush[NSTAGE]         flush into each stage register (combinational)
//   cf_req / cf_target      branch/jump redirect raised by stage CF_STAGE
//   trap_req / trap_vector  trap entry
//   wfi_req / int_pending   sleep request / wake source
//   fetch_redirect/target   registered redirect to fetch, held until fetch_ack
//   o_halted                core asleep
//   perf_stalls/flushes     saturating performance counters

module frv_pipeline_ctrl #(
    parameter int NSTAGE   = 4,
    parameter int CF_STAGE = 2,
    parameter int XLEN     = 32
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic [NSTAGE-1:0] s_valid,
    input  logic [NSTAGE-1:0] s_stall,
    output logic [NSTAGE-1:0] s_ready,
    output logic [NSTAGE-1:0] s_flush,
    input  logic              cf_req,
    input  logic [XLEN-1:0]   cf_target,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_vector,
    input  logic              wfi_req,
    input  logic              int_pending,
    output logic              fetch_redirect,
    output logic [XLEN-1:0]   fetch_target,
    input  logic              fetch_ack,
    output logic              o_halted,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SLEEP    = 2'd2
    } state_t;

    // Stages younger than the control-flow stage hold wrong-path work.
    localparam logic [NSTAGE-1:0] CF_MASK = {NSTAGE{1'b1}} >> (NSTAGE - CF_STAGE);

    state_t            state_q, state_d;
    logic [NSTAGE-1:0] rdy_chain;
    logic [NSTAGE-1:0] ready_d;
    logic [NSTAGE-1:0] flush_d;
    logic              tgt_load;
    logic [XLEN-1:0]   tgt_val;
    logic              cf_take;
    logic              redirect_q;
    logic [XLEN-1:0]   target_q;

    // Backpressure chain: a stage may accept if it is not stalled and the
    // stage in front either accepts or is empty. Built oldest-first inside
    // one process so the chain is an ordered evaluation, not a net loop.
    always_comb begin
        rdy_chain = '0;
        rdy_chain[NSTAGE-1] = !s_stall[NSTAGE-1];
        for (int i = NSTAGE - 2; i >= 0; i--)
            rdy_chain[i] = !s_stall[i] && (rdy_chain[i+1] || !s_valid[i+1]);
    end

    assign cf_take = cf_req && s_valid[CF_STAGE] && rdy_chain[CF_STAGE];

    always_comb begin
        state_d  = state_q;
        ready_d  = rdy_chain;
        flush_d  = '0;
        tgt_load = 1'b0;
        tgt_val  = trap_vector;
        case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    flush_d  = '1;
                    tgt_load = 1'b1;
                    state_d  = ST_REDIRECT;
                end else if (cf_take) begin
                    flush_d  = CF_MASK;
                    tgt_load = 1'b1;
                    tgt_val  = cf_target;
                    state_d  = ST_REDIRECT;
                end else if (wfi_req) begin
                    state_d  = ST_SLEEP;
                end
            end
            ST_REDIRECT: begin
                // Nothing new may enter until fetch has taken the new PC.
                ready_d[0] = 1'b0;
                if (trap_req) begin
                    // A trap beats a same-cycle ack: the ack was for the
                    // old target, so the handshake restarts.
                    flush_d  = '1;
                    tgt_load = 1'b1;
                end else if (fetch_ack) begin
                    state_d  = ST_RUN;
                end
            end
            ST_SLEEP: begin
                ready_d = '0;
                if (trap_req) begin
                    flush_d  = '1;
                    tgt_load = 1'b1;
                    state_d  = ST_REDIRECT;
                end else if (int_pending) begin
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q    <= ST_RUN;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= (state_d == ST_REDIRECT);
            if (tgt_load)
                target_q <= tgt_val;
        end
    end

    assign s_ready        = ready_d;
    assign s_flush        = g_resetn ? flush_d : '0;
    assign fetch_redirect = redirect_q;
    assign fetch_target   = target_q;
    assign o_halted       = (state_q == ST_SLEEP);

`ifdef FRV_PIPELINE_CTRL_PERF_EN
    logic [31:0] stalls_q;
    logic [31:0] flushes_q;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            if (s_valid[0] && !ready_d[0] && (stalls_q != 32'hFFFF_FFFF))
                stalls_q <= stalls_q + 32'd1;
            if ((|flush_d) && (flushes_q != 32'hFFFF_FFFF))
                flushes_q <= flushes_q + 32'd1;
        end
    end

    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    // Stage 0 valid only feeds the stall counter.
    logic unused_valid0;
    assign unused_valid0 = s_valid[0];
    assign perf_stalls   = '0;
    assign perf_flushes  = '0;
`endif

endmodule

// File: tb/tb_frv_pipeline_ctrl.sv
module tb_frv_pipeline_ctrl;

    localparam int N  = 4;
    localparam int CF = 2;
    localparam int XL = 32;

    logic          g_clk = 1'b0;
    logic          g_resetn;
    logic [N-1:0]  s_valid, s_stall, s_ready, s_flush;
    logic          cf_req, trap_req, wfi_req, int_pending, fetch_ack;
    logic [XL-1:0] cf_target, trap_vector, fetch_target;
    logic          fetch_redirect, o_halted;
    logic [31:0]   perf_stalls, perf_flushes;

    frv_pipeline_ctrl #(.NSTAGE(N), .CF_STAGE(CF), .XLEN(XL)) dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .s_valid        (s_valid),
        .s_stall        (s_stall),
        .s_ready        (s_ready),
        .s_flush        (s_flush),
        .cf_req         (cf_req),
        .cf_target      (cf_target),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .wfi_req        (wfi_req),
        .int_pending    (int_pending),
        .fetch_redirect (fetch_redirect),
        .fetch_target   (fetch_target),
        .fetch_ack      (fetch_ack),
        .o_halted       (o_halted),
        .perf_stalls    (perf_stalls),
        .perf_flushes   (perf_flushes)
    );

    always #5 g_clk = ~g_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A stage can accept if, walking towards the oldest stage, we reach an
    // empty slot (or the end of the pipe) before meeting any stalled stage.
    function automatic logic [N-1:0] want_ready(input logic [N-1:0] v, input logic [N-1:0] st);
        logic [N-1:0] r;
        r = '1;
        for (int i = 0; i < N; i++) begin
            for (int j = i; j < N; j++) begin
                if (st[j]) begin
                    r[i] = 1'b0;
                    break;
                end
                if (j == N - 1) break;
                if (!v[j+1]) break;
            end
        end
        return r;
    endfunction

    // Behavioural model: "busy redirecting", "asleep", pending target, counts.
    bit            m_redir, m_asleep;
    logic [XL-1:0] m_tgt;
    longint        m_stalls, m_flushes;

    always @(negedge g_clk) begin
        logic [N-1:0] er, ef, mask;
        logic         take_cf;
        longint       es, efl;
        if (!g_resetn) begin
            m_redir = 0; m_asleep = 0; m_tgt = '0; m_stalls = 0; m_flushes = 0;
            chk("rst_flush", s_flush, 0);
            chk("rst_redirect", fetch_redirect, 0);
            chk("rst_target", fetch_target, 0);
            chk("rst_halted", o_halted, 0);
            chk("rst_pstall", perf_stalls, 0);
            chk("rst_pflush", perf_flushes, 0);
        end else begin
            mask = '0;
            for (int i = 0; i < CF; i++) mask[i] = 1'b1;
            er = want_ready(s_valid, s_stall);
            if (m_asleep) er = '0;
            else if (m_redir) er[0] = 1'b0;
            take_cf = !m_redir && !m_asleep && cf_req && s_valid[CF] && er[CF];
            ef = trap_req ? '1 : (take_cf ? mask : '0);
`ifdef FRV_PIPELINE_CTRL_PERF_EN
            es = m_stalls; efl = m_flushes;
`else
            es = 0; efl = 0;
`endif
            chk("m_ready", s_ready, er);
            chk("m_flush", s_flush, ef);
            chk("m_redirect", fetch_redirect, m_redir);
            chk("m_target", fetch_target, m_tgt);
            chk("m_halted", o_halted, m_asleep);
            chk("m_pstall", perf_stalls, es);
            chk("m_pflush", perf_flushes, efl);
            if (s_valid[0] && !er[0] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (ef != 0 && m_flushes < 64'hFFFF_FFFF) m_flushes++;
            if (trap_req) begin
                m_redir = 1; m_asleep = 0; m_tgt = trap_vector;
            end else if (take_cf) begin
                m_redir = 1; m_tgt = cf_target;
            end else if (m_redir) begin
                if (fetch_ack) m_redir = 0;
            end else if (m_asleep) begin
                if (int_pending) m_asleep = 0;
            end else if (wfi_req) begin
                m_asleep = 1;
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn = 0;
        s_valid = '0; s_stall = '0;
        cf_req = 0; cf_target = '0; trap_req = 0; trap_vector = '0;
        wfi_req = 0; int_pending = 0; fetch_ack = 0;
        tick(); tick();
        chk("reset_redirect", fetch_redirect, 0);
        chk("reset_target", fetch_target, 0);
        chk("reset_halted", o_halted, 0);
        chk("reset_perf", {perf_stalls, perf_flushes}, 0);
        g_resetn = 1;
        tick();

        // Backpressure
        s_valid = 4'b1111; s_stall = 4'b1000; #1;
        chk("bp_full", s_ready, 4'b0000);
        s_valid = 4'b0111; #1;
        chk("bp_bubble", s_ready, 4'b0111);
        s_stall = '0;

        // Branch redirect
        tick();
        s_valid = 4'b0100; cf_req = 1; cf_target = 32'h8000_0100; #1;
        chk("br_flush", s_flush, 4'b0011);
        tick();
        cf_req = 0; #1;
        chk("br_flush_once", s_flush, 4'b0000);
        chk("br_redirect", fetch_redirect, 1);
        chk("br_target", fetch_target, 32'h8000_0100);
        chk("br_ready0", s_ready[0], 0);
        tick();
        chk("br_hold", fetch_redirect, 1);
        fetch_ack = 1;
        tick();
        fetch_ack = 0; #1;
        chk("br_done", fetch_redirect, 0);

        // Trap and branch together
        trap_req = 1; cf_req = 1; trap_vector = 32'h40; cf_target = 32'h1234; #1;
        chk("both_flush", s_flush, 4'b1111);
        tick();
        trap_req = 0; cf_req = 0; #1;
        chk("both_target", fetch_target, 32'h40);

        // Trap during redirect beats a same-cycle ack
        trap_req = 1; trap_vector = 32'h200; fetch_ack = 1; #1;
        chk("rt_flush", s_flush, 4'b1111);
        tick();
        trap_req = 0; fetch_ack = 0; #1;
        chk("rt_stay", fetch_redirect, 1);
        chk("rt_target", fetch_target, 32'h200);
        fetch_ack = 1;
        tick();
        fetch_ack = 0;

        // Sleep and wake
        s_valid = '0; wfi_req = 1;
        tick();
        wfi_req = 0; #1;
        chk("slp_halted", o_halted, 1);
        chk("slp_ready", s_ready, 4'b0000);
        int_pending = 1;
        tick();
        int_pending = 0; #1;
        chk("wake_halted", o_halted, 0);
        chk("wake_ready", s_ready, 4'b1111);

        // Reset in the middle of a redirect
        s_valid = 4'b0100; cf_req = 1; cf_target = 32'h1000;
        tick();
        cf_req = 0; #1;
        chk("mr_redirect", fetch_redirect, 1);
        g_resetn = 0; #1;
        chk("mr_drop", fetch_redirect, 0);
        chk("mr_target", fetch_target, 0);
        chk("mr_perf", {perf_stalls, perf_flushes}, 0);
        tick();
        g_resetn = 1;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            g_resetn    = ($urandom_range(0, 199) != 0);
            s_valid     = N'($urandom);
            s_stall     = '0;
            for (int b = 0; b < N; b++) s_stall[b] = ($urandom_range(0, 4) == 0);
            cf_req      = ($urandom_range(0, 3) == 0);
            cf_target   = $urandom;
            trap_req    = ($urandom_range(0, 19) == 0);
            trap_vector = $urandom;
            wfi_req     = ($urandom_range(0, 19) == 0);
            int_pending = ($urandom_range(0, 4) == 0);
            fetch_ack   = ($urandom_range(0, 2) == 0);
            tick();
        end
        g_resetn = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
